uart_boot_loader: RTL
=====================

# uart_boot_loader

Frame decoder that sits directly downstream of the UART receiver and consumes its AXI-Stream byte output. It parses a simple boot frame (sync, word count, little-endian 32-bit payload words, XOR checksum) and writes each assembled word into instruction/data memory through a one-cycle write port. It reports completion or failure and holds the CPU in reset while a load is in progress.

## Interface
- `ADDR_W`, 10: memory word-address width.
- `BASE_ADDR`, 0: word address of the first payload word; `ADDR_W` bits.
- `TIMEOUT_CYCLES`, 1000000: idle-cycle limit inside a frame; must be ≥2.
- `Clk`  in  1  clock; single clock domain.
- `Rst_n`  in  1  synchronous, active-low reset.
- `S_axis_tdata`  in  8  received byte.
- `S_axis_tvalid`  in  1  byte valid.
- `S_axis_tready`  out  1  loader can accept a byte.
- `Mem_wr_en`  out  1  one-cycle memory write strobe.
- `Mem_addr`  out  `ADDR_W`  word address of the write.
- `Mem_wr_data`  out  32  word to write.
- `Busy`  out  1  frame in progress.
- `Cpu_rst`  out  1  CPU hold; equals `Busy`.
- `Load_done`  out  1  one-cycle pulse: frame accepted, checksum good.
- `Load_error`  out  1  one-cycle pulse: checksum mismatch or timeout.

## Operation
- Frame format: `0xA5`, CNT_LO, CNT_HI, then 4·N payload bytes (N = {CNT_HI,CNT_LO}, 16-bit), then CHK.
- Payload words are little-endian: the first byte goes to [7:0], the fourth to [31:24].
- CHK must equal the XOR of CNT_LO, CNT_HI and every payload byte. The sync byte is excluded.
- A handshake occurs when `S_axis_tvalid & S_axis_tready`.
- FSM states: ST_IDLE, ST_CNT_LO, ST_CNT_HI, ST_PAYLOAD, ST_WRITE, ST_CHECKSUM.
- ST_IDLE: bytes other than `0xA5` are consumed and discarded. `0xA5` → ST_CNT_LO; the checksum accumulator, byte index, word counter and address are cleared (address set to `BASE_ADDR`).
- ST_CNT_LO → ST_CNT_HI on handshake.
- ST_CNT_HI on handshake: → ST_CHECKSUM if N==0, else → ST_PAYLOAD.
- ST_PAYLOAD: bytes shift into the word register and the byte index increments. The 4th-byte handshake → ST_WRITE.
- ST_WRITE (exactly one cycle):
  - `Mem_wr_en`=1 with `Mem_addr`/`Mem_wr_data` stable; `S_axis_tready`=0.
  - Then the address increments (wraps modulo 2^`ADDR_W`) and the word counter increments.
  - → ST_CHECKSUM if the counter reached N, else → ST_PAYLOAD.
- ST_CHECKSUM on handshake:
  - match → `Load_done` pulse, ST_IDLE;
  - mismatch → `Load_error` pulse, ST_IDLE.
- Words already written are not rolled back on error.
- Timeout:
  - The counter clears in ST_IDLE and on every handshake; otherwise it increments.
  - In any non-IDLE state, when it reaches `TIMEOUT_CYCLES`−1 with no handshake that cycle, the next cycle pulses `Load_error` and returns to ST_IDLE.
- `S_axis_tready`=1 in all states except ST_WRITE. The memory port has no backpressure.

## Timing
- Reset (`Rst_n`=0 at a clock edge) forces ST_IDLE and all outputs to 0 except `S_axis_tready`=1 (combinational from state). `Mem_addr`=`BASE_ADDR`, `Mem_wr_data`=0.
- Reset mid-frame aborts immediately. No `Load_error` is generated and no further writes occur.
- `Busy`/`Cpu_rst` = (state != ST_IDLE), registered via state. They rise the cycle after the sync handshake and fall in the same cycle `Load_done`/`Load_error` is high.
- Write latency: `Mem_wr_en` is high the cycle immediately after the 4th payload byte's handshake.
- `Load_done`/`Load_error` are high the cycle after the CHK handshake (or after the timeout cycle). They are never both high.
- Throughput: at most 4 bytes per 5 cycles in the payload. One byte per cycle elsewhere.
- If a `0xA5` byte appears inside a frame, it is treated as data, not as a resync.
- Timeout and a handshake in the same cycle: the handshake wins and the counter clears.

## Test plan
- Frame A5 01 00 78 56 34 12 09, `BASE_ADDR`=0x010 → one `Mem_wr_en` pulse with addr 0x010, data 0x12345678, then `Load_done`=1 one cycle after CHK. `Busy` is high exactly during the frame.
- Same frame with CHK=0x08 → same single write, then a `Load_error` pulse and no `Load_done`.
- Bytes 00 FF 13 then A5 00 00 00 → the garbage is discarded, there are no writes, and `Load_done` pulses.
- N=3 with `BASE_ADDR`=2^`ADDR_W`−1, `tvalid` held high → addresses 0x3FF, 0x000, 0x001. `tready` is low exactly in each write cycle.
- `TIMEOUT_CYCLES`=16; send A5 02 00 AA and then stall → `Load_error` 16 cycles after the last handshake, then ST_IDLE. A following good frame loads normally.
- Assert `Rst_n`=0 after the 5th payload byte of an N=2 frame → outputs return to reset values, no second write, no pulses.

Source files
------------

// File: rtl/uart_boot_loader.sv
// Boot frame decoder: A5, count, little-endian words, XOR checksum.
// Writes each word to memory and holds the CPU in reset while loading.
`timescale 1ns/1ps
module uart_boot_loader #(
    parameter int unsigned          ADDR_W         = 10,
    parameter logic [ADDR_W-1:0]    BASE_ADDR      = '0,
    parameter int unsigned          TIMEOUT_CYCLES = 1000000
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [7:0]        S_axis_tdata,
    input  logic              S_axis_tvalid,
    output logic              S_axis_tready,
    output logic              Mem_wr_en,
    output logic [ADDR_W-1:0] Mem_addr,
    output logic [31:0]       Mem_wr_data,
    output logic              Busy,
    output logic              Cpu_rst,
    output logic              Load_done,
    output logic              Load_error
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CNT_LO,
        ST_CNT_HI,
        ST_PAYLOAD,
        ST_WRITE,
        ST_CHECKSUM
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        chk_q, chk_d;
    logic [1:0]        idx_q, idx_d;
    logic [31:0]       word_q, word_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [15:0]       wcnt_q, wcnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              hs;

    assign S_axis_tready = (state_q != ST_WRITE);
    assign hs            = S_axis_tvalid & S_axis_tready;
    assign Mem_wr_en     = (state_q == ST_WRITE);
    assign Mem_addr      = addr_q;
    assign Mem_wr_data   = word_q;
    assign Busy          = (state_q != ST_IDLE);
    assign Cpu_rst       = Busy;
    assign Load_done     = done_q;
    assign Load_error    = err_q;

    always_comb begin
        state_d = state_q;
        chk_d   = chk_q;
        idx_d   = idx_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        wcnt_d  = wcnt_q;
        addr_d  = addr_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        tmo_d   = (state_q == ST_IDLE || hs) ? '0 : tmo_q + TMO_W'(1);

        unique case (state_q)
            ST_IDLE: begin
                if (hs && S_axis_tdata == 8'hA5) begin
                    state_d = ST_CNT_LO;
                    chk_d   = '0;
                    idx_d   = '0;
                    wcnt_d  = '0;
                    addr_d  = BASE_ADDR;
                end
            end
            ST_CNT_LO: begin
                if (hs) begin
                    cnt_d[7:0] = S_axis_tdata;
                    chk_d      = chk_q ^ S_axis_tdata;
                    state_d    = ST_CNT_HI;
                end
            end
            ST_CNT_HI: begin
                if (hs) begin
                    cnt_d[15:8] = S_axis_tdata;
                    chk_d       = chk_q ^ S_axis_tdata;
                    if ({S_axis_tdata, cnt_q[7:0]} == 16'd0) begin
                        state_d = ST_CHECKSUM;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (hs) begin
                    word_d = {S_axis_tdata, word_q[31:8]};
                    chk_d  = chk_q ^ S_axis_tdata;
                    idx_d  = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                addr_d = addr_q + ADDR_W'(1);
                wcnt_d = wcnt_q + 16'd1;
                if (wcnt_q + 16'd1 == cnt_q) begin
                    state_d = ST_CHECKSUM;
                end else begin
                    state_d = ST_PAYLOAD;
                end
            end
            ST_CHECKSUM: begin
                if (hs) begin
                    done_d  = (S_axis_tdata == chk_q);
                    err_d   = (S_axis_tdata != chk_q);
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A stalled frame is abandoned; a same-cycle handshake takes priority
        if (state_q != ST_IDLE && !hs && tmo_q == TMO_LAST) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
            chk_q   <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            cnt_q   <= '0;
            wcnt_q  <= '0;
            addr_q  <= BASE_ADDR;
            tmo_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            chk_q   <= chk_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
            addr_q  <= addr_d;
            tmo_q   <= tmo_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule
